// File: rtl/sat_hold_monitor_if.sv
// Handshake bundle between the saturation source/controller and the hold monitor.
interface sat_hold_monitor_if #(
  parameter int unsigned CNT_W = 4
);
  logic             i1;
  logic             lvl_in;
  logic             ack;
  logic             alarm;
  logic             busy;
  logic [CNT_W-1:0] evt_cnt;
  logic [2:0]       state_o;

  modport master (
    output i1, lvl_in, ack,
    input  alarm, busy, evt_cnt, state_o
  );

  modport slave (
    input  i1, lvl_in, ack,
    output alarm, busy, evt_cnt, state_o
  );
endinterface

// File: rtl/sat_hold_monitor.sv
// Raises an alarm once lvl_in has been sampled high for HOLD_LEN consecutive
// armed edges; alarm is held until acknowledged and cannot retrigger until
// lvl_in drops. Counts alarm entries with a saturating counter.
module sat_hold_monitor #(
  parameter int unsigned HOLD_LEN = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic               clk,
  input logic               reset,
  sat_hold_monitor_if.slave mon_if
);

  localparam int unsigned HOLD_W = 4;
  localparam logic [CNT_W-1:0] EVT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_ALARM    = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W:0]     hold_inc;
  logic [CNT_W-1:0]    evt_q;
  logic                alarm_q;
  logic                busy_q;
  logic                enter_alarm;

  assign hold_inc    = {1'b0, hold_q} + (HOLD_W+1)'(1);
  assign enter_alarm = (state_d == ST_ALARM) && (state_q != ST_ALARM);

  // Next-state and hold-counter logic; hold counter is zero outside HOLD.
  always_comb begin
    state_d = ST_IDLE;
    hold_d  = '0;
    case (state_q)
      ST_IDLE: begin
        state_d = mon_if.i1 ? ST_ARMED : ST_IDLE;
      end
      ST_ARMED: begin
        if (!mon_if.i1) begin
          state_d = ST_IDLE;
        end else if (mon_if.lvl_in) begin
          if (HOLD_LEN == 1) begin
            state_d = ST_ALARM;
          end else begin
            state_d = ST_HOLD;
            hold_d  = HOLD_W'(1);
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HOLD: begin
        if (!mon_if.i1) begin
          state_d = ST_IDLE;
        end else if (!mon_if.lvl_in) begin
          state_d = ST_ARMED;
        end else if (hold_inc == (HOLD_W+1)'(HOLD_LEN)) begin
          state_d = ST_ALARM;
        end else begin
          state_d = ST_HOLD;
          hold_d  = hold_inc[HOLD_W-1:0];
        end
      end
      // Arm enable is deliberately ignored while the alarm is pending.
      ST_ALARM: begin
        if (!mon_if.ack) begin
          state_d = ST_ALARM;
        end else if (mon_if.lvl_in) begin
          state_d = ST_WAIT_LOW;
        end else begin
          state_d = mon_if.i1 ? ST_ARMED : ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (!mon_if.lvl_in) begin
          state_d = mon_if.i1 ? ST_ARMED : ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, hold counter, registered outputs and saturating event counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      evt_q   <= '0;
      alarm_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      alarm_q <= (state_d == ST_ALARM);
      busy_q  <= (state_d == ST_HOLD) || (state_d == ST_ALARM) ||
                 (state_d == ST_WAIT_LOW);
      if (enter_alarm && (evt_q != EVT_MAX)) begin
        evt_q <= evt_q + CNT_W'(1);
      end
    end
  end

  assign mon_if.alarm   = alarm_q;
  assign mon_if.busy    = busy_q;
  assign mon_if.evt_cnt = evt_q;
  assign mon_if.state_o = state_q;

endmodule

// File: tb/tb_sat_hold_monitor.sv
// Directed testbench for sat_hold_monitor (HOLD_LEN=4, CNT_W=4).
module tb_sat_hold_monitor;

  localparam int unsigned HOLD_LEN = 4;
  localparam int unsigned CNT_W    = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   exp_evt;

  sat_hold_monitor_if #(.CNT_W(CNT_W)) mon_if ();

  sat_hold_monitor #(.HOLD_LEN(HOLD_LEN), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .mon_if (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input int st, input int al, input int bz, input int ev);
    check({tag, ".state"}, 32'(mon_if.state_o), 32'(st));
    check({tag, ".alarm"}, 32'(mon_if.alarm),   32'(al));
    check({tag, ".busy"},  32'(mon_if.busy),    32'(bz));
    check({tag, ".evt"},   32'(mon_if.evt_cnt), 32'(ev));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    mon_if.i1     = 1'b0;
    mon_if.lvl_in = 1'b0;
    mon_if.ack    = 1'b0;
    step(1);
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // Arm with lvl low: stays ARMED, idle outputs.
    mon_if.i1 = 1'b1;
    step(5);
    check_all("armed", 1, 0, 0, 0);

    // Four consecutive highs raise the alarm on the fourth edge.
    mon_if.lvl_in = 1'b1;
    step(1);
    check_all("hold_t0", 2, 0, 1, 0);
    step(1);
    check("hold_t1.alarm", 32'(mon_if.alarm), 32'd0);
    step(1);
    check("hold_t2.alarm", 32'(mon_if.alarm), 32'd0);
    step(1);
    check_all("alarm1", 3, 1, 1, 1);

    // Ack with lvl still high goes to WAIT_LOW; no retrigger while high.
    mon_if.ack = 1'b1;
    step(1);
    check_all("wait_low", 4, 0, 1, 1);
    mon_if.ack = 1'b0;
    step(10);
    check_all("no_retrig", 4, 0, 1, 1);
    mon_if.lvl_in = 1'b0;
    step(1);
    check_all("rearm", 1, 0, 0, 1);
    mon_if.lvl_in = 1'b1;
    step(4);
    check_all("alarm2", 3, 1, 1, 2);

    // Disarm is ignored in ALARM; ack with lvl low and i1 low goes IDLE.
    mon_if.i1     = 1'b0;
    mon_if.lvl_in = 1'b0;
    step(1);
    check("alarm_ign_i1.state", 32'(mon_if.state_o), 32'd3);
    mon_if.ack = 1'b1;
    step(1);
    check_all("ack_idle", 0, 0, 0, 2);
    mon_if.ack = 1'b0;

    // Broken run: 3 highs, 1 low, then 4 highs.
    mon_if.i1 = 1'b1;
    step(1);
    mon_if.lvl_in = 1'b1;
    step(3);
    check_all("run3", 2, 0, 1, 2);
    mon_if.lvl_in = 1'b0;
    step(1);
    check_all("run_break", 1, 0, 0, 2);
    mon_if.lvl_in = 1'b1;
    step(3);
    check("run2_3.alarm", 32'(mon_if.alarm), 32'd0);
    step(1);
    check_all("alarm3", 3, 1, 1, 3);
    mon_if.ack    = 1'b1;
    mon_if.lvl_in = 1'b0;
    step(1);
    check_all("ack_armed", 1, 0, 0, 3);

    // Ack outside ALARM has no effect.
    step(1);
    check_all("ack_armed_noeff", 1, 0, 0, 3);
    mon_if.ack = 1'b0;

    // Disarm mid-HOLD with hold counter at 2.
    mon_if.lvl_in = 1'b1;
    step(2);
    check("hold2.state", 32'(mon_if.state_o), 32'd2);
    mon_if.i1 = 1'b0;
    step(1);
    check_all("hold_disarm", 0, 0, 0, 3);

    // Reset mid-HOLD discards the partial run.
    mon_if.i1     = 1'b1;
    mon_if.lvl_in = 1'b0;
    step(1);
    mon_if.lvl_in = 1'b1;
    step(2);
    check("hold_pre_rst.state", 32'(mon_if.state_o), 32'd2);
    reset = 1'b1;
    step(1);
    check_all("hold_reset", 0, 0, 0, 0);
    reset = 1'b0;
    mon_if.lvl_in = 1'b0;
    step(1);
    mon_if.lvl_in = 1'b1;
    step(3);
    check("post_rst_3.alarm", 32'(mon_if.alarm), 32'd0);
    step(1);
    check_all("post_rst_alarm", 3, 1, 1, 1);

    // Reset mid-ALARM, then 17 alarm/ack cycles saturate the counter at 15.
    reset = 1'b1;
    step(1);
    check_all("alarm_reset", 0, 0, 0, 0);
    reset   = 1'b0;
    exp_evt = 0;
    for (int n = 0; n < 17; n++) begin
      mon_if.ack    = 1'b0;
      mon_if.lvl_in = 1'b0;
      step(1);
      mon_if.lvl_in = 1'b1;
      step(4);
      exp_evt = (exp_evt == 15) ? 15 : exp_evt + 1;
      check($sformatf("sat_%0d.evt", n), 32'(mon_if.evt_cnt), 32'(exp_evt));
      mon_if.ack    = 1'b1;
      mon_if.lvl_in = 1'b0;
      step(1);
    end
    mon_if.ack = 1'b0;
    step(2);
    check_all("sat_final", 1, 0, 0, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sat_hold_monitor.md
SAT_HOLD_MONITOR -- requirements
Module: sat_hold_monitor

Interface
REQ-001 Parameter: HOLD_LEN, default 4, legal 1..15; consecutive sampled-high cycles of lvl_in required to raise alarm.
REQ-002 Parameter: CNT_W, default 4; width of evt_cnt.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: i1  input  1  arm enable; 1 = monitor armed, 0 = disarmed.
REQ-006 Port: lvl_in  input  1  saturation flag (z1) from upstream 2-bit saturating counter.
REQ-007 Port: ack  input  1  alarm acknowledge; sampled only in ALARM.
REQ-008 Port: alarm  output  1  registered; high exactly while state = ALARM.
REQ-009 Port: busy  output  1  registered; high while state is HOLD, ALARM or WAIT_LOW.
REQ-010 Port: evt_cnt  output  CNT_W  count of ALARM entries, saturating.
REQ-011 Port: state_o  output  3  current state encoding for observability.

Function
REQ-012 Block SHALL implement FSM with fixed encoding IDLE=0, ARMED=1, HOLD=2, ALARM=3, WAIT_LOW=4; codes 5-7 SHALL map to IDLE next cycle.
REQ-013 Block SHALL keep a hold counter of 4 bits; it is cleared whenever state leaves HOLD.
REQ-014 IDLE: i1=1 -> ARMED; else stay.
REQ-015 ARMED: i1=0 -> IDLE (priority); lvl_in=1 and HOLD_LEN=1 -> ALARM; lvl_in=1 and HOLD_LEN>1 -> HOLD with hold counter = 1; else stay.
REQ-016 HOLD: i1=0 -> IDLE (priority); lvl_in=0 -> ARMED; lvl_in=1 and hold counter+1 = HOLD_LEN -> ALARM; else hold counter increments.
REQ-017 alarm SHALL rise on the edge at which lvl_in has been sampled high on HOLD_LEN consecutive edges while armed; latency from first high sample = HOLD_LEN-1 further edges.
REQ-018 ALARM: i1 changes SHALL be ignored; ack=0 -> stay; ack=1 and lvl_in=1 -> WAIT_LOW; ack=1 and lvl_in=0 -> ARMED if i1=1, else IDLE.
REQ-019 WAIT_LOW: lvl_in=0 -> ARMED if i1=1, else IDLE; otherwise stay; no retrigger while lvl_in stays high.
REQ-020 ack outside ALARM SHALL have no effect.
REQ-021 evt_cnt SHALL increment by 1 on every transition into ALARM and hold at 2^CNT_W-1 once reached (no wrap).
REQ-022 evt_cnt SHALL be cleared only by reset.
REQ-023 lvl_in held high permanently (upstream saturated) SHALL produce exactly one alarm per arm/ack cycle.

Reset
REQ-024 reset=1 at a rising edge SHALL force state IDLE, hold counter 0, evt_cnt 0, alarm 0, busy 0, state_o 0 after that edge, from any state, overriding all other inputs.
REQ-025 Reset mid-HOLD or mid-ALARM SHALL discard the partial run; no evt_cnt increment for it.

Verification
REQ-026 Reset, i1=1, lvl_in=0 for 5 cycles -> state_o=1, alarm=0, busy=0, evt_cnt=0.
REQ-027 HOLD_LEN=4, armed, lvl_in=1 on edges t..t+3 -> alarm=1 and state_o=3 after edge t+3, evt_cnt=1, alarm=0 after edges t..t+2.
REQ-028 lvl_in high 3 edges, low 1, high 4 -> no alarm after the first run; alarm after 4th high of the second run.
REQ-029 In ALARM, ack=1 with lvl_in=1 -> state_o=4, alarm=0, busy=1; lvl_in stays high 10 cycles -> no new alarm; lvl_in=0 then 4 highs -> alarm, evt_cnt=2.
REQ-030 In HOLD with hold counter=2, i1=0 -> IDLE next edge; separately reset=1 in HOLD -> all outputs 0 next edge.
REQ-031 Drive 17 complete alarm/ack sequences with CNT_W=4 -> evt_cnt reaches 15 and stays 15.
